// File: rtl/quar_request_ctrl.sv
// Button-to-QUAR front end: 2-FF synchronisers, debouncer, press-edge detector and handshake FSM.
// Optional QUAR_COUNT_EN macro builds a saturating completed-quarantine counter on quar_count.
module quar_request_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 20
) (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       btnC,
  input  logic       resetQUAR,
  output logic       QUAR,
  output logic       resetFLAG,
  output logic [1:0] state,
  output logic [7:0] quar_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    ACK    = 2'd2,
    DONE   = 2'd3
  } st_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  st_t             st;
  logic            btn_m;
  logic            btn_s;
  logic            rq_m;
  logic            rq_s;
  logic [CNT_W-1:0] cnt;
  logic            db;
  logic            db_d;
  logic            press;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      btn_m <= 1'b0;
      btn_s <= 1'b0;
      rq_m  <= 1'b0;
      rq_s  <= 1'b0;
    end else begin
      btn_m <= btnC;
      btn_s <= btn_m;
      rq_m  <= resetQUAR;
      rq_s  <= rq_m;
    end
  end

  // A level change is accepted only after it has persisted for DEBOUNCE_CYCLES consecutive edges.
  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt  <= '0;
      db   <= 1'b0;
      db_d <= 1'b0;
    end else begin
      db_d <= db;
      if (btn_s == db) begin
        cnt <= '0;
      end else if (cnt == CNT_LAST) begin
        db  <= btn_s;
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign press = db & ~db_d;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      st        <= IDLE;
      QUAR      <= 1'b0;
      resetFLAG <= 1'b0;
    end else begin
      case (st)
        IDLE: begin
          if (press) begin
            st   <= ACTIVE;
            QUAR <= 1'b1;
          end
        end
        ACTIVE: begin
          // End-of-countdown request takes priority over a coincident press.
          if (rq_s) begin
            st        <= ACK;
            QUAR      <= 1'b0;
            resetFLAG <= 1'b1;
          end
        end
        ACK: begin
          if (!rq_s) begin
            st <= DONE;
          end
        end
        DONE: begin
          if (press) begin
            st        <= ACTIVE;
            QUAR      <= 1'b1;
            resetFLAG <= 1'b0;
          end
        end
        default: begin
          st        <= IDLE;
          QUAR      <= 1'b0;
          resetFLAG <= 1'b0;
        end
      endcase
    end
  end

  assign state = st;

`ifdef QUAR_COUNT_EN
  logic [7:0] qcnt;

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      qcnt <= 8'd0;
    end else if (st == ACTIVE && rq_s && qcnt != 8'd255) begin
      qcnt <= qcnt + 8'd1;
    end
  end

  assign quar_count = qcnt;
`else
  assign quar_count = 8'd0;
`endif

endmodule
